// File: rtl/rf_pkg.sv
// Shared constants for the rename register file: default tag width, the reserved
// "no tag" value and the hardwired-zero register index.
package rf_pkg;

    localparam int unsigned TAG_W     = 4;
    localparam int unsigned NREG_DEF  = 32;
    localparam int unsigned REG_AW    = $clog2(NREG_DEF);
    localparam logic [TAG_W-1:0] EMPTY_TAG = '0;
    localparam int unsigned ZERO_REG  = 0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the rename register file: decode, x0 masking and,
// when RF_COMMIT_BYPASS_EN is defined, forwarding of same-cycle commit data.
module rf_read_port #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAG_W = rf_pkg::TAG_W,
    parameter int unsigned NCM   = 1
) (
    input  logic [$clog2(NREG)-1:0]      rd_reg_i,
    input  logic [XLEN-1:0]              data_i [NREG],
    input  logic [TAG_W-1:0]             tag_i  [NREG],
    input  logic                         rdy_i,
    input  logic [NCM-1:0]               cm_valid_i,
    input  logic [NCM*$clog2(NREG)-1:0]  cm_reg_i,
    input  logic [NCM*XLEN-1:0]          cm_data_i,
    input  logic [NCM-1:0]               cm_clr_i,
    output logic [XLEN-1:0]              rd_data_o,
    output logic [TAG_W-1:0]             rd_tag_o
);

    localparam int unsigned AW = $clog2(NREG);
    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(rf_pkg::EMPTY_TAG);

    always_comb begin
        rd_data_o = data_i[rd_reg_i];
        rd_tag_o  = tag_i[rd_reg_i];
`ifdef RF_COMMIT_BYPASS_EN
        // Ascending loop so the highest matching commit slot wins.
        for (int c = 0; c < NCM; c++) begin
            if (rdy_i && cm_valid_i[c] && (cm_reg_i[c*AW +: AW] == rd_reg_i)) begin
                rd_data_o = cm_data_i[c*XLEN +: XLEN];
                rd_tag_o  = cm_clr_i[c] ? NO_TAG : tag_i[rd_reg_i];
            end
        end
`endif
        if (rd_reg_i == AW'(rf_pkg::ZERO_REG)) begin
            rd_data_o = '0;
            rd_tag_o  = NO_TAG;
        end
    end

`ifndef RF_COMMIT_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{rdy_i, cm_valid_i, cm_reg_i, cm_data_i, cm_clr_i};
`endif

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags, commit/rename update
// priority, global flush and busy-register count. Option: RF_COMMIT_BYPASS_EN.
module rename_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAG_W = rf_pkg::TAG_W,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NREN  = 1,
    parameter int unsigned NCM   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          flush,
    input  logic [NRD*$clog2(NREG)-1:0]   rd_reg,
    output logic [NRD*XLEN-1:0]           rd_data,
    output logic [NRD*TAG_W-1:0]          rd_tag,
    input  logic [NREN-1:0]               ren_valid,
    input  logic [NREN*$clog2(NREG)-1:0]  ren_reg,
    input  logic [NREN*TAG_W-1:0]         ren_tag,
    input  logic [NCM-1:0]                cm_valid,
    input  logic [NCM*$clog2(NREG)-1:0]   cm_reg,
    input  logic [NCM*XLEN-1:0]           cm_data,
    input  logic [NCM*TAG_W-1:0]          cm_tag,
    output logic [$clog2(NREG):0]         busy_cnt
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] X0 = AW'(rf_pkg::ZERO_REG);

    logic [XLEN-1:0]  data_q [NREG];
    logic [XLEN-1:0]  data_d [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [TAG_W-1:0] tag_d  [NREG];
    logic [CW-1:0]    busy_cnt_q, busy_cnt_d;
    logic [NREG-1:0]  ren_hit;
    logic [NCM-1:0]   cm_clr;

    // Registers receiving an accepted rename this cycle; such a rename blocks commit tag clears.
    always_comb begin
        ren_hit = '0;
        if (rdy && !flush) begin
            for (int r = 0; r < NREN; r++) begin
                if (ren_valid[r] && (ren_reg[r*AW +: AW] != X0)) begin
                    ren_hit[ren_reg[r*AW +: AW]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cm_clr = '0;
        for (int c = 0; c < NCM; c++) begin
            cm_clr[c] = rdy && cm_valid[c] && (cm_reg[c*AW +: AW] != X0) &&
                        (cm_tag[c*TAG_W +: TAG_W] == tag_q[cm_reg[c*AW +: AW]]) &&
                        !ren_hit[cm_reg[c*AW +: AW]];
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            data_d[i] = data_q[i];
            tag_d[i]  = tag_q[i];
        end
        if (rdy) begin
            for (int c = 0; c < NCM; c++) begin
                if (cm_valid[c] && (cm_reg[c*AW +: AW] != X0)) begin
                    data_d[cm_reg[c*AW +: AW]] = cm_data[c*XLEN +: XLEN];
                    if (cm_clr[c]) begin
                        tag_d[cm_reg[c*AW +: AW]] = '0;
                    end
                end
            end
            if (!flush) begin
                for (int r = 0; r < NREN; r++) begin
                    if (ren_valid[r] && (ren_reg[r*AW +: AW] != X0)) begin
                        tag_d[ren_reg[r*AW +: AW]] = ren_tag[r*TAG_W +: TAG_W];
                    end
                end
            end
        end
        if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                tag_d[i] = '0;
            end
        end
    end

    // Popcount of the registered tags, itself registered; it tracks the tags a cycle behind.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + CW'(tag_q[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_cnt_q <= '0;
        end else begin
            data_q     <= data_d;
            tag_q      <= tag_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        rf_read_port #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .TAG_W (TAG_W),
            .NCM   (NCM)
        ) u_rd (
            .rd_reg_i   (rd_reg[p*AW +: AW]),
            .data_i     (data_q),
            .tag_i      (tag_q),
            .rdy_i      (rdy),
            .cm_valid_i (cm_valid),
            .cm_reg_i   (cm_reg),
            .cm_data_i  (cm_data),
            .cm_clr_i   (cm_clr),
            .rd_data_o  (rd_data[p*XLEN +: XLEN]),
            .rd_tag_o   (rd_tag[p*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Table-driven bench for rename_regfile: per-cycle stimulus records with hand-computed
// expectations, checked through a scoreboard queue; follows RF_COMMIT_BYPASS_EN.
module tb_rename_regfile;

`ifdef RF_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic [9:0]  rd_reg;
    logic [63:0] rd_data;
    logic [7:0]  rd_tag;
    logic [0:0]  ren_valid;
    logic [4:0]  ren_reg;
    logic [3:0]  ren_tag;
    logic [0:0]  cm_valid;
    logic [4:0]  cm_reg;
    logic [31:0] cm_data;
    logic [3:0]  cm_tag;
    logic [5:0]  busy_cnt;

    rename_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .rd_reg    (rd_reg),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .ren_valid (ren_valid),
        .ren_reg   (ren_reg),
        .ren_tag   (ren_tag),
        .cm_valid  (cm_valid),
        .cm_reg    (cm_reg),
        .cm_data   (cm_data),
        .cm_tag    (cm_tag),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, flush;
        logic        rv; logic [4:0] rr; logic [3:0] rt;
        logic        cv; logic [4:0] cr; logic [3:0] ct; logic [31:0] cd;
        logic [4:0]  a0, a1;
        logic [31:0] d0; logic [3:0] t0;
        logic [31:0] d1; logic [3:0] t1;
        logic [5:0]  bz;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] d0; logic [3:0] t0;
        logic [31:0] d1; logic [3:0] t1;
        logic [5:0]  bz;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(logic rdy_v, logic fl, logic rv, logic [4:0] rr, logic [3:0] rt,
                                logic cv, logic [4:0] cr, logic [3:0] ct, logic [31:0] cd,
                                logic [4:0] a0, logic [4:0] a1,
                                logic [31:0] d0, logic [3:0] t0, logic [31:0] d1,
                                logic [3:0] t1, logic [5:0] bz);
        vec_t v;
        v.rdy = rdy_v; v.flush = fl;
        v.rv = rv; v.rr = rr; v.rt = rt;
        v.cv = cv; v.cr = cr; v.ct = ct; v.cd = cd;
        v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.t0 = t0; v.d1 = d1; v.t1 = t1; v.bz = bz;
        return v;
    endfunction

    function automatic void check(string name, int id, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
        end
    endfunction

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        rdy = v.rdy; flush = v.flush;
        ren_valid = v.rv; ren_reg = v.rr; ren_tag = v.rt;
        cm_valid = v.cv; cm_reg = v.cr; cm_tag = v.ct; cm_data = v.cd;
        rd_reg = {v.a1, v.a0};
        e.id = id; e.d0 = v.d0; e.t0 = v.t0; e.d1 = v.d1; e.t1 = v.t1; e.bz = v.bz;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check("rd_data0", e.id, rd_data[31:0], e.d0);
        check("rd_tag0", e.id, 32'(rd_tag[3:0]), 32'(e.t0));
        check("rd_data1", e.id, rd_data[63:32], e.d1);
        check("rd_tag1", e.id, 32'(rd_tag[7:4]), 32'(e.t1));
        check("busy_cnt", e.id, 32'(busy_cnt), 32'(e.bz));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] dbf;
        dbf = 32'hDEAD_BEEF;
        // rdy fl  rv rr rt   cv cr ct cd            a0 a1   d0 t0 d1 t1 busy
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 5, 3, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 3, dbf, 5, 5,
                          BYP ? dbf : 0, BYP ? 0 : 3, BYP ? dbf : 0, BYP ? 0 : 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 6, dbf, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, dbf, 0, dbf, 0, 0));
        vecs.push_back(mk(1, 0, 1, 5, 3, 0, 0, 0, 0, 5, 5, dbf, 0, dbf, 0, 0));
        vecs.push_back(mk(1, 0, 1, 5, 7, 0, 0, 0, 0, 5, 5, dbf, 3, dbf, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 3, 32'h11, 5, 5,
                          BYP ? 32'h11 : dbf, 7, BYP ? 32'h11 : dbf, 7, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 32'h11, 7, 32'h11, 7, 1));
        vecs.push_back(mk(1, 0, 1, 6, 2, 0, 0, 0, 0, 6, 5, 0, 0, 32'h11, 7, 1));
        vecs.push_back(mk(1, 0, 1, 6, 4, 1, 6, 2, 32'h66, 6, 5,
                          BYP ? 32'h66 : 0, 2, 32'h11, 7, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 5, 32'h66, 4, 32'h11, 7, 2));
        vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 0, 1, 2, 2, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 2));
        vecs.push_back(mk(1, 0, 1, 3, 3, 0, 0, 0, 0, 2, 3, 0, 2, 0, 0, 3));
        vecs.push_back(mk(1, 0, 1, 4, 4, 0, 0, 0, 0, 3, 4, 0, 3, 0, 0, 4));
        vecs.push_back(mk(1, 1, 1, 7, 5, 1, 2, 9, 32'h55, 4, 2,
                          0, 4, BYP ? 32'h55 : 0, 2, 5));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 7, 32'h55, 0, 0, 0, 6));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 0, 0, 32'h11, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 5, 1, 0, 0, 32'hFF, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 7, 1, 0, 0, 0, 0, 7, 7, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8, 6, 1, 7, 1, 32'hA5, 7, 8, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 1, 32'hA5, 7, 8,
                          BYP ? 32'hA5 : 0, BYP ? 0 : 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 8, 32'hA5, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'hA5, 0, 32'hA5, 0, 0));

        rst = 1'b1; rdy = 1'b0; flush = 1'b0;
        ren_valid = '0; ren_reg = '0; ren_tag = '0;
        cm_valid = '0; cm_reg = '0; cm_tag = '0; cm_data = '0;
        rd_reg = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset while flushing and renaming must clear data too, and drop the rename.
        apply(mk(1, 0, 1, 9, 5, 0, 0, 0, 0, 9, 10, 0, 0, 0, 0, 0), 100);
        apply(mk(1, 0, 0, 0, 0, 1, 10, 0, 32'h77, 9, 10,
                 0, 5, BYP ? 32'h77 : 0, 0, 0), 101);
        rst = 1'b1; flush = 1'b1;
        ren_valid = 1'b1; ren_reg = 5'd11; ren_tag = 4'd2;
        cm_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 10, 0, 0, 0, 0, 0), 102);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 10, 11, 0, 0, 0, 0, 0), 103);

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Parametrised architectural register file with per-register rename tags for the out-of-order core. It serves NRD decoder read ports, accepts NREN rename writes from dispatch and NCM commit writes from the ROB per cycle. Reads can optionally bypass same-cycle commits. It sits between decoder/dispatch and ROB commit, and supports a global flush on misprediction.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural register count; index 0 hardwired zero
- TAG_W, 4, rename tag width; tag 0 reserved as "no tag"
- NRD, 2, read ports
- NREN, 1, rename ports
- NCM, 1, commit ports
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state except flush/reset
- flush  in  1  misprediction clear
- rd_reg  in  NRD*$clog2(NREG)  read addresses, port p at slice p
- rd_data  out  NRD*XLEN  register value
- rd_tag  out  NRD*TAG_W  pending tag, 0 if value valid
- ren_valid  in  NREN  rename request per slot
- ren_reg  in  NREN*$clog2(NREG)  destination register
- ren_tag  in  NREN*TAG_W  ROB tag assigned
- cm_valid  in  NCM  commit request per slot
- cm_reg  in  NCM*$clog2(NREG)  committed register
- cm_data  in  NCM*XLEN  committed value
- cm_tag  in  NCM*TAG_W  ROB tag of committing entry
- busy_cnt  out  $clog2(NREG)+1  number of registers with nonzero tag

## Operation
- State: data[NREG], tag[NREG]. Reset: all data and tags 0; outputs rd_data=0, rd_tag=0, busy_cnt=0.
- Register 0: writes, renames, commits ignored; reads always data 0, tag 0.
- Commit slot c (cm_valid[c], cm_reg≠0, rdy): data[cm_reg] <= cm_data; tag[cm_reg] <= 0 only if cm_tag == stored tag and no rename to that register this cycle.
- Rename slot r (ren_valid[r], ren_reg≠0, rdy, !flush): tag[ren_reg] <= ren_tag.
- Priority on same register, same cycle: rename beats commit for tag; higher-index rename slot wins; higher-index commit slot wins data; tag clears if any matching commit matches.
- Flush (independent of rdy): commits in that cycle still write data; all tags <= 0; renames dropped; data otherwise kept.
- rst has priority over flush; data cleared.
- rdy low, no flush: no state change.
- busy_cnt: popcount of tag[i]≠0, derived from registered state.

## Timing
- Reads combinational from registered state; zero-cycle latency.
- Commit/rename visible to reads the cycle after the clock edge (without bypass).
- busy_cnt updates one cycle after the causing edge.
- Renames never bypass to reads: same-cycle reads see pre-rename tag; intra-group dependencies are the decoder's responsibility.

## Configuration
- RF_COMMIT_BYPASS_EN defined: read port whose rd_reg matches a valid same-cycle commit (rdy high) returns cm_data (highest matching slot); rd_tag returns 0 if that commit would clear the tag, else stored tag. Rename still not bypassed.
- Undefined: reads return registered state only; commit visible next cycle.

## Structure
- Shared package rf_pkg: TAG_W, EMPTY_TAG (=0), REG_AW = $clog2(NREG), zero-register index constant.
- Sub-module rf_read_port instantiated NRD times: address decode, x0 masking, optional commit bypass mux.
- Top level holds arrays, update priority logic, busy popcount.

## Test plan
- Reset then read x5 on both ports -> data 0, tag 0, busy_cnt 0.
- Rename x5 tag 3; next cycle commit x5 tag 3 data 0xDEADBEEF -> after commit, x5 data 0xDEADBEEF, tag 0, busy_cnt 1 -> 0.
- Rename x5 tag 3, then rename x5 tag 7, then commit x5 tag 3 data 0x11 -> data 0x11, tag stays 7.
- Same cycle: commit x6 tag 2 (matching) and rename x6 tag 4 -> tag 4, data updated.
- Rename x1..x4, flush with concurrent commit x2 data 0x55 -> all tags 0, x2=0x55, busy_cnt 0; rename in flush cycle ignored.
- With RF_COMMIT_BYPASS_EN: commit x7 tag 1 data 0xA5 while reading x7 -> same cycle rd_data 0xA5, rd_tag 0; without macro -> old value, tag 1; rdy low -> no update either way.
